// File: rtl/mcu_cmd_pkg.sv
// Shared definitions for the MCU downlink command scheduler.
// Contents:
//   - downlink nibble encodings for idle and the four broadcast commands
//   - the legal range of coincidence codes
//   - CTRL opcodes and register word offsets
//   - the scheduler state enum
//   - small helper functions
package mcu_cmd_pkg;

  // Downlink nibble encodings, decoded on the rocstar side.
  localparam logic [3:0] NIB_IDLE = 4'h0;
  localparam logic [3:0] NIB_SYNC = 4'hA;
  localparam logic [3:0] NIB_SAVE = 4'hB;
  localparam logic [3:0] NIB_RUN  = 4'hC;
  localparam logic [3:0] NIB_STOP = 4'hD;

  // Coincidence codes must stay below the command space.
  localparam logic [3:0] CODE_MIN = 4'h1;
  localparam logic [3:0] CODE_MAX = 4'h7;

  // CTRL opcodes, in bits [2:0] of a CTRL write.
  localparam logic [2:0] OP_SYNC = 3'd1;
  localparam logic [2:0] OP_SAVE = 3'd2;
  localparam logic [2:0] OP_RUN  = 3'd3;
  localparam logic [2:0] OP_STOP = 3'd4;
  localparam logic [2:0] OP_SEQ  = 3'd5;

  // Register word offsets from BASE_ADDR.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_GAP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Register reset values.
  localparam logic [7:0]  MASK_RST = 8'hFF;
  localparam logic [15:0] GAP_RST  = 16'd100;

  // Scheduler states; the encoding is visible in STATUS[4:2].
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GAP  = 3'd2,
    ST_ARM2 = 3'd3
  } sched_state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op >= OP_SYNC) && (op <= OP_SEQ);
  endfunction

  // Nibble sent in the first issue of an operation.
  // A sequence opens with SYNC.
  function automatic logic [3:0] op_first_nibble(input logic [2:0] op);
    logic [3:0] nib;
    case (op)
      OP_SYNC: nib = NIB_SYNC;
      OP_SAVE: nib = NIB_SAVE;
      OP_RUN:  nib = NIB_RUN;
      OP_STOP: nib = NIB_STOP;
      OP_SEQ:  nib = NIB_SYNC;
      default: nib = NIB_IDLE;
    endcase
    return nib;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mcu_lane_mux.sv
// One downlink lane.
// Registers the nibble that drives one MCU-to-rocstar link. The nibble is
// chosen in priority order:
//   1. the broadcast command nibble;
//   2. the lane's coincidence code, only when it lies inside CODE_MIN..CODE_MAX;
//   3. IDLE otherwise.
// A corrupt or out-of-range code can therefore never look like a command.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   i_valid    : coincidence result present on this lane this cycle
//   i_code     : 4-bit coincidence code
//   i_cmd_en   : drive the command nibble on the next edge
//   i_cmd_nib  : command nibble to broadcast
//   o_nib      : registered downlink nibble
module mcu_lane_mux
  import mcu_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [3:0] i_code,
  input  logic       i_cmd_en,
  input  logic [3:0] i_cmd_nib,
  output logic [3:0] o_nib
);

  logic       w_code_legal;
  logic [3:0] w_next_nib;
  logic [3:0] r_nib;

  assign w_code_legal = (i_code >= CODE_MIN) && (i_code <= CODE_MAX);

  always_comb begin
    w_next_nib = NIB_IDLE;
    if (i_cmd_en) begin
      w_next_nib = i_cmd_nib;
    end else if (i_valid && w_code_legal) begin
      w_next_nib = i_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib <= NIB_IDLE;
    end else begin
      r_nib <= w_next_nib;
    end
  end

  assign o_nib = r_nib;

endmodule

// File: rtl/mcu_cmd_scheduler.sv
// MCU downlink command scheduler.
//
// Owns the eight MCU-to-rocstar downlink nibbles (A1..A4, B1..B4).
// Each link normally carries its coincidence code. The scheduler breaks in
// with SYNC, SAVE, RUN or STOP broadcasts on the lanes selected by MASK.
// SEQ issues SYNC, waits GAP cycles, then issues SAVE. This lets every
// masked board zero and latch its clkcnt on the same edge.
//
// A command goes out atomically, on all masked lanes on one edge. It waits
// for every masked lane to be free of coincidence traffic. After MAX_DEFER
// cycles of waiting it goes out anyway and overwrites that traffic. Each
// overwritten code is counted in drop_cnt.
//
// Bus protocol:
//   - A transfer is qualified by bstrobe, which is high for one cycle.
//   - With bwr high it is a write; it is accepted on that clock edge
//     with no back-pressure.
//   - Reads need no strobe: brddata is a combinational function of baddr.
//   - brddata is 0 outside BASE_ADDR..BASE_ADDR+3, so mcu_logic can OR the
//     read-data sources together.
//
// Register map:
//   +0 CTRL   (write-only) bits[2:0]: 1=SYNC 2=SAVE 3=RUN 4=STOP 5=SEQ
//   +1 MASK   [7:0], lane enable for broadcasts
//   +2 GAP    [15:0], cycles between SYNC and SAVE; 0 acts as 1
//   +3 STATUS {drop_cnt[7:0], 3'b0, state[2:0], seq_done, busy}
//
// Ports:
//   clk, rst          : 100 MHz clock, synchronous active-high reset
//   baddr, bwrdata    : bus address / write data
//   bwr, bstrobe      : write qualifier / one-cycle access strobe
//   brddata           : read data
//   coinc_valid[7:0]  : per-link coincidence present (bit0=A1 .. bit7=B4)
//   coinc_code[31:0]  : per-link 4-bit code, nibble i for link i
//   link_out[31:0]    : registered downlink nibbles, nibble i for link i
//   busy              : an operation is in progress
module mcu_cmd_scheduler
  import mcu_cmd_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0040,
  parameter int unsigned MAX_DEFER = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baddr,
  input  logic [15:0] bwrdata,
  input  logic        bwr,
  input  logic        bstrobe,
  output logic [15:0] brddata,
  input  logic [7:0]  coinc_valid,
  input  logic [31:0] coinc_code,
  output logic [31:0] link_out,
  output logic        busy
);

  localparam int DEFER_W = (MAX_DEFER == 0) ? 1 : $clog2(MAX_DEFER + 1);

  // State and registers.
  sched_state_e        r_state;
  sched_state_e        w_next_state;
  logic [2:0]          r_op;
  logic [7:0]          r_mask;
  logic [15:0]         r_gap;
  logic [15:0]         r_gap_cnt;
  logic [DEFER_W-1:0]  r_defer;
  logic [7:0]          r_drop_cnt;
  logic                r_seq_done;
  // Set in the cycle the command nibble is on the links. This keeps busy
  // high until the broadcast has actually left.
  logic                r_issue_q;

  // Bus decode.
  logic [15:0] w_off;
  logic        w_hit;
  logic [1:0]  w_reg;
  logic        w_wr;
  logic        w_ctrl_start;
  logic        w_busy;
  logic [15:0] w_status;
  logic [15:0] w_rddata;

  // Issue logic.
  logic [7:0]  w_masked_active;
  logic        w_issue_ok;
  logic        w_issue;
  logic [3:0]  w_cmd_nib;
  logic        w_set_seq_done;
  logic [15:0] w_gap_eff;
  logic [3:0]  w_drop_inc;
  logic [8:0]  w_drop_sum;

  // The subtraction wraps, so addresses below BASE_ADDR miss as well.
  assign w_off = baddr - BASE_ADDR;
  assign w_hit = (w_off[15:2] == 14'd0);
  assign w_reg = w_off[1:0];
  assign w_wr  = bwr & bstrobe & w_hit;

  assign w_busy       = (r_state != ST_IDLE) | r_issue_q;
  assign w_ctrl_start = w_wr & (w_reg == REG_CTRL) & op_is_valid(bwrdata[2:0]) & ~w_busy;

  assign w_masked_active = r_mask & coinc_valid;
  assign w_issue_ok      = (w_masked_active == 8'h00) || (r_defer == DEFER_W'(MAX_DEFER));
  assign w_gap_eff       = (r_gap == 16'd0) ? 16'd1 : r_gap;

  // Next-state logic and the outputs of the issue logic.
  always_comb begin
    w_next_state   = r_state;
    w_issue        = 1'b0;
    w_cmd_nib      = NIB_IDLE;
    w_set_seq_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ctrl_start) begin
          w_next_state = ST_ARM;
        end
      end
      ST_ARM: begin
        w_cmd_nib = op_first_nibble(r_op);
        if (w_issue_ok) begin
          w_issue      = 1'b1;
          w_next_state = (r_op == OP_SEQ) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        // Counter starts at 0 on entry, so GAP takes w_gap_eff cycles.
        if (r_gap_cnt >= (w_gap_eff - 16'd1)) begin
          w_next_state = ST_ARM2;
        end
      end
      ST_ARM2: begin
        w_cmd_nib = NIB_SAVE;
        if (w_issue_ok) begin
          w_issue        = 1'b1;
          w_set_seq_done = 1'b1;
          w_next_state   = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The defer counter restarts on every state change. That covers entry to
  // ARM and to ARM2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_defer <= '0;
    end else if (r_state != w_next_state) begin
      r_defer <= '0;
    end else if (((r_state == ST_ARM) || (r_state == ST_ARM2)) && !w_issue_ok) begin
      r_defer <= r_defer + DEFER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_GAP)) begin
      r_gap_cnt <= 16'd0;
    end else begin
      r_gap_cnt <= r_gap_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= 3'd0;
    end else if (w_ctrl_start) begin
      r_op <= bwrdata[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= MASK_RST;
      r_gap  <= GAP_RST;
    end else if (w_wr) begin
      if (w_reg == REG_MASK) begin
        r_mask <= bwrdata[7:0];
      end
      if (w_reg == REG_GAP) begin
        r_gap <= bwrdata;
      end
    end
  end

  // Masked lanes that carried a code in the issue cycle lose it.
  assign w_drop_inc = popcount8(w_masked_active);
  assign w_drop_sum = {1'b0, r_drop_cnt} + {5'd0, w_drop_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_issue) begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_done <= 1'b0;
      r_issue_q  <= 1'b0;
    end else begin
      r_issue_q <= w_issue;
      if (w_ctrl_start) begin
        r_seq_done <= 1'b0;
      end else if (w_set_seq_done) begin
        r_seq_done <= 1'b1;
      end
    end
  end

  // Read path.
  assign w_status = {r_drop_cnt, 3'b000, r_state, r_seq_done, w_busy};

  always_comb begin
    w_rddata = 16'h0000;
    if (w_hit) begin
      case (w_reg)
        REG_MASK:   w_rddata = {8'h00, r_mask};
        REG_GAP:    w_rddata = r_gap;
        REG_STATUS: w_rddata = w_status;
        default:    w_rddata = 16'h0000;
      endcase
    end
  end

  assign brddata = w_rddata;
  assign busy    = w_busy;

  // Lanes.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    mcu_lane_mux u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (coinc_valid[g]),
      .i_code    (coinc_code[4*g +: 4]),
      .i_cmd_en  (w_issue & r_mask[g]),
      .i_cmd_nib (w_cmd_nib),
      .o_nib     (link_out[4*g +: 4])
    );
  end

endmodule

// File: tb/tb_mcu_cmd_scheduler.sv
// Testbench for mcu_cmd_scheduler.
//
// Each operation runs in a fixed window of NW cycles. The CTRL write comes
// in cycle 0. Per-cycle lane traffic comes from the sv/sc tables.
//
// The reference model takes the issue rule directly from the register
// description:
//   - the first issue cycle is the earliest cycle at which no masked lane is
//     active, or the cycle at which MAX_DEFER waiting cycles have passed;
//   - SEQ's SAVE search starts GAP+1 cycles after the SYNC issue.
//
// From these issue cycles the model writes the expected link words into
// exp_q and the expected busy flags into exp_busy_q.
module tb_mcu_cmd_scheduler;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int MAXD = 8;
  localparam int NW   = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baddr;
  logic [15:0] bwrdata;
  logic        bwr;
  logic        bstrobe;
  logic [15:0] brddata;
  logic [7:0]  coinc_valid;
  logic [31:0] coinc_code;
  logic [31:0] link_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Stimulus tables and captured outputs for one window.
  logic [7:0]  sv [NW];
  logic [31:0] sc [NW];
  logic [31:0] obs_link [NW];
  logic        obs_busy [NW];

  // Scoreboard.
  logic [31:0] exp_q[$];
  logic        exp_busy_q[$];

  // Model of the architectural registers.
  logic [7:0] m_mask;
  int         m_gap;
  int         m_drop;
  logic       m_seq_done;

  // Clock and reset.
  always #5 clk = ~clk;

  mcu_cmd_scheduler #(.BASE_ADDR(BASE), .MAX_DEFER(MAXD)) dut (
    .clk         (clk),
    .rst         (rst),
    .baddr       (baddr),
    .bwrdata     (bwrdata),
    .bwr         (bwr),
    .bstrobe     (bstrobe),
    .brddata     (brddata),
    .coinc_valid (coinc_valid),
    .coinc_code  (coinc_code),
    .link_out    (link_out),
    .busy        (busy)
  );

  // Driver tasks. Every task starts and ends 1 ns after a rising edge.
  task automatic bus_write(input logic [1:0] off, input logic [15:0] data);
    baddr   = BASE + {14'd0, off};
    bwrdata = data;
    bwr     = 1'b1;
    bstrobe = 1'b1;
    @(posedge clk); #1;
    bwr     = 1'b0;
    bstrobe = 1'b0;
    if (off == 2'd1) m_mask = data[7:0];
    if (off == 2'd2) m_gap = int'(data);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    baddr = addr;
    @(negedge clk);
    data = brddata;
    @(posedge clk); #1;
  endtask

  task automatic fill_idle();
    for (int c = 0; c < NW; c++) begin
      sv[c] = 8'h00;
      sc[c] = $urandom;
    end
  endtask

  // Drive op in cycle 0 and op2 in cycle 1. op2 should be ignored, because
  // it arrives while the DUT is busy.
  task automatic run_window(input logic [2:0] op, input logic [2:0] op2);
    for (int c = 0; c < NW; c++) begin
      coinc_valid = sv[c];
      coinc_code  = sc[c];
      if (c < 2) begin
        baddr   = BASE;
        bwrdata = {13'd0, (c == 0) ? op : op2};
        bwr     = 1'b1;
        bstrobe = 1'b1;
      end else begin
        baddr   = BASE + 16'd3;
        bwr     = 1'b0;
        bstrobe = 1'b0;
      end
      @(negedge clk);
      obs_link[c] = link_out;
      obs_busy[c] = busy;
      @(posedge clk); #1;
    end
    coinc_valid = 8'h00;
    coinc_code  = 32'h0;
    bwr         = 1'b0;
    bstrobe     = 1'b0;
  endtask

  // Reference model: expected link words for cycles 1..NW-1 and expected
  // busy flags for cycles 0..NW-1.
  task automatic build_expect(input logic [2:0] op);
    int t1, t2, tl, ge, s, t;
    logic [3:0] nib1, nb, cd;
    logic [31:0] w, cw;
    t1 = -1;
    t2 = -1;
    nib1 = 4'h0;
    if (op >= 3'd1 && op <= 3'd5) begin
      case (op)
        3'd1: nib1 = 4'hA;
        3'd2: nib1 = 4'hB;
        3'd3: nib1 = 4'hC;
        3'd4: nib1 = 4'hD;
        default: nib1 = 4'hA;
      endcase
      t1 = 1;
      while (t1 < 1 + MAXD && (m_mask & sv[t1]) != 8'h00) t1++;
      m_drop = m_drop + $countones(m_mask & sv[t1]);
      m_seq_done = 1'b0;
      if (op == 3'd5) begin
        ge = (m_gap == 0) ? 1 : m_gap;
        s  = t1 + 1 + ge;
        t2 = s;
        while (t2 < s + MAXD && (m_mask & sv[t2]) != 8'h00) t2++;
        m_drop = m_drop + $countones(m_mask & sv[t2]);
        m_seq_done = 1'b1;
      end
      if (m_drop > 255) m_drop = 255;
    end
    tl = (t2 >= 0) ? t2 : t1;
    for (int c = 1; c < NW; c++) begin
      t  = c - 1;
      cw = sc[t];
      w  = 32'h0;
      for (int i = 0; i < 8; i++) begin
        cd = cw[4*i +: 4];
        if (t == t1 && m_mask[i]) nb = nib1;
        else if (t == t2 && m_mask[i]) nb = 4'hB;
        else if (sv[t][i] && cd >= 4'h1 && cd <= 4'h7) nb = cd;
        else nb = 4'h0;
        w[4*i +: 4] = nb;
      end
      exp_q.push_back(w);
    end
    for (int c = 0; c < NW; c++) begin
      exp_busy_q.push_back((tl >= 0) && (c >= 1) && (c <= tl + 1));
    end
  endtask

  // Tests.
  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1; baddr = BASE; bwrdata = 16'h0; bwr = 1'b0; bstrobe = 1'b0;
    coinc_valid = 8'h00; coinc_code = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_mask = 8'hFF; m_gap = 100; m_drop = 0; m_seq_done = 1'b0;
    @(negedge clk);
    checks++; if (link_out !== 32'h0) begin failures++; $display("FAIL reset_link got %h want %h", link_out, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #1;
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 16'h00FF) begin failures++; $display("FAIL reset_mask got %h want 00ff", d); end
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 16'd100) begin failures++; $display("FAIL reset_gap got %0d want 100", d); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_status got %h want 0000", d); end
    bus_read(BASE, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL read_ctrl got %h want 0000", d); end
    bus_read(BASE + 16'd4, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL read_above got %h want 0000", d); end
    bus_read(BASE - 16'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL read_below got %h want 0000", d); end
  endtask

  task automatic test_run_cmd();
    logic [31:0] ew; logic eb; logic [15:0] d;
    fill_idle();
    build_expect(3'd3);
    run_window(3'd3, 3'd1);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL run_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL run_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
    checks++; if (obs_link[2] !== 32'hCCCCCCCC) begin failures++; $display("FAIL run_t2 got %h want cccccccc", obs_link[2]); end
    checks++; if (obs_busy[3] !== 1'b0) begin failures++; $display("FAIL run_busy_t3 got %b want 0", obs_busy[3]); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== {8'(m_drop), 6'd0, m_seq_done, 1'b0}) begin failures++; $display("FAIL run_status got %h want %h", d, {8'(m_drop), 6'd0, m_seq_done, 1'b0}); end
  endtask

  task automatic test_seq();
    logic [31:0] ew; logic eb; logic [15:0] d;
    bus_write(2'd2, 16'd5);
    fill_idle();
    build_expect(3'd5);
    run_window(3'd5, 3'd3);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL seq_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL seq_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
    checks++; if (obs_link[2] !== 32'hAAAAAAAA) begin failures++; $display("FAIL seq_sync got %h want aaaaaaaa", obs_link[2]); end
    checks++; if (obs_link[8] !== 32'hBBBBBBBB) begin failures++; $display("FAIL seq_save got %h want bbbbbbbb", obs_link[8]); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d[1] !== 1'b1) begin failures++; $display("FAIL seq_done got %b want 1", d[1]); end
  endtask

  task automatic test_defer();
    logic [31:0] ew; logic eb; logic [15:0] d;
    bus_write(2'd1, 16'h0001);
    for (int c = 0; c < NW; c++) begin
      sv[c] = 8'h01;
      sc[c] = 32'h00000003;
    end
    build_expect(3'd1);
    run_window(3'd1, 3'd2);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL defer_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL defer_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
    checks++; if (obs_link[2 + MAXD] !== 32'h0000000A) begin failures++; $display("FAIL defer_sync got %h want 0000000a", obs_link[2 + MAXD]); end
    checks++; if (obs_link[1 + MAXD] !== 32'h00000003) begin failures++; $display("FAIL defer_before got %h want 00000003", obs_link[1 + MAXD]); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d[15:8] !== 8'd1) begin failures++; $display("FAIL defer_drop got %0d want 1", d[15:8]); end
  endtask

  task automatic test_partial_mask();
    logic [31:0] ew; logic eb;
    bus_write(2'd1, 16'h000F);
    for (int c = 0; c < NW; c++) begin
      sv[c] = 8'h80;
      sc[c] = 32'h50000000;
    end
    build_expect(3'd2);
    run_window(3'd2, 3'd4);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL pmask_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL pmask_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
    checks++; if (obs_link[2] !== 32'h5000BBBB) begin failures++; $display("FAIL pmask_t2 got %h want 5000bbbb", obs_link[2]); end
  endtask

  task automatic test_sanitize();
    logic [31:0] ew; logic eb;
    for (int c = 0; c < NW; c++) begin
      sv[c] = 8'h0F;
      sc[c] = 32'h00007AF0;
    end
    build_expect(3'd0);
    run_window(3'd0, 3'd0);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL sanitize_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL sanitize_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
    checks++; if (obs_link[3] !== 32'h00007000) begin failures++; $display("FAIL sanitize_t3 got %h want 00007000", obs_link[3]); end
  endtask

  task automatic test_mask_zero();
    logic [31:0] ew; logic eb;
    bus_write(2'd1, 16'h0000);
    for (int c = 0; c < NW; c++) begin
      sv[c] = $urandom;
      sc[c] = $urandom;
    end
    build_expect(3'd3);
    run_window(3'd3, 3'd1);
    for (int c = 0; c < NW; c++) begin
      eb = exp_busy_q.pop_front();
      checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL mzero_busy c=%0d got %b want %b", c, obs_busy[c], eb); end
      if (c > 0) begin
        ew = exp_q.pop_front();
        checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL mzero_link c=%0d got %h want %h", c, obs_link[c], ew); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ew; logic eb;
    bus_write(2'd1, 16'h00FF);
    for (int k = 0; k < 2; k++) begin
      fill_idle();
      build_expect((k == 0) ? 3'd4 : 3'd1);
      run_window((k == 0) ? 3'd4 : 3'd1, 3'd3);
      for (int c = 0; c < NW; c++) begin
        eb = exp_busy_q.pop_front();
        checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL b2b_busy k=%0d c=%0d got %b want %b", k, c, obs_busy[c], eb); end
        if (c > 0) begin
          ew = exp_q.pop_front();
          checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL b2b_link k=%0d c=%0d got %h want %h", k, c, obs_link[c], ew); end
        end
      end
    end
    checks++; if (obs_link[2] !== 32'hAAAAAAAA) begin failures++; $display("FAIL b2b_second got %h want aaaaaaaa", obs_link[2]); end
  endtask

  task automatic test_reset_mid_gap();
    logic [15:0] d;
    bus_write(2'd2, 16'd20);
    for (int c = 0; c < 40; c++) begin
      coinc_valid = 8'h00;
      coinc_code  = 32'h0;
      rst = (c == 5);
      if (c == 0) begin
        baddr = BASE; bwrdata = 16'd5; bwr = 1'b1; bstrobe = 1'b1;
      end else begin
        bwr = 1'b0; bstrobe = 1'b0;
      end
      @(negedge clk);
      if (c == 2) begin
        checks++; if (link_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL rgap_sync got %h want aaaaaaaa", link_out); end
      end
      if (c >= 3) begin
        checks++; if (link_out !== 32'h0) begin failures++; $display("FAIL rgap_link c=%0d got %h want 00000000", c, link_out); end
      end
      if (c >= 1) begin
        checks++; if (busy !== (c <= 5)) begin failures++; $display("FAIL rgap_busy c=%0d got %b want %b", c, busy, (c <= 5)); end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_mask = 8'hFF; m_gap = 100; m_drop = 0; m_seq_done = 1'b0;
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 16'd100) begin failures++; $display("FAIL rgap_gapreg got %0d want 100", d); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rgap_status got %h want 0000", d); end
  endtask

  task automatic test_random_traffic();
    logic [31:0] ew; logic eb; logic [15:0] d;
    int dens, sel;
    logic [2:0] op, op2;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 3);
      bus_write(2'd1, (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h00FF : 16'($urandom_range(0, 255)));
      bus_write(2'd2, 16'($urandom_range(0, 12)));
      dens = $urandom_range(0, 8);
      for (int c = 0; c < NW; c++) begin
        for (int i = 0; i < 8; i++) sv[c][i] = ($urandom_range(1, 8) <= dens);
        sc[c] = $urandom;
      end
      op  = 3'($urandom_range(0, 7));
      op2 = (op >= 3'd1 && op <= 3'd5) ? 3'($urandom_range(1, 5)) : 3'd0;
      build_expect(op);
      run_window(op, op2);
      for (int c = 0; c < NW; c++) begin
        eb = exp_busy_q.pop_front();
        checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL rand_busy it=%0d op=%0d c=%0d got %b want %b", it, op, c, obs_busy[c], eb); end
        if (c > 0) begin
          ew = exp_q.pop_front();
          checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL rand_link it=%0d op=%0d c=%0d got %h want %h", it, op, c, obs_link[c], ew); end
        end
      end
      bus_read(BASE + 16'd3, d);
      checks++; if (d !== {8'(m_drop), 6'd0, m_seq_done, 1'b0}) begin failures++; $display("FAIL rand_status it=%0d got %h want %h", it, d, {8'(m_drop), 6'd0, m_seq_done, 1'b0}); end
    end
  endtask

  task automatic test_drop_saturate();
    logic [31:0] ew; logic eb; logic [15:0] d;
    bus_write(2'd1, 16'h00FF);
    for (int it = 0; it < 33; it++) begin
      for (int c = 0; c < NW; c++) begin
        sv[c] = 8'hFF;
        sc[c] = $urandom;
      end
      build_expect(3'd3);
      run_window(3'd3, 3'd4);
      for (int c = 0; c < NW; c++) begin
        eb = exp_busy_q.pop_front();
        checks++; if (obs_busy[c] !== eb) begin failures++; $display("FAIL sat_busy it=%0d c=%0d got %b want %b", it, c, obs_busy[c], eb); end
        if (c > 0) begin
          ew = exp_q.pop_front();
          checks++; if (obs_link[c] !== ew) begin failures++; $display("FAIL sat_link it=%0d c=%0d got %h want %h", it, c, obs_link[c], ew); end
        end
      end
    end
    bus_read(BASE + 16'd3, d);
    checks++; if (d[15:8] !== 8'hFF) begin failures++; $display("FAIL sat_drop got %0d want 255", d[15:8]); end
  endtask

  // Sequence and final report.
  initial begin
    test_reset();
    test_run_cmd();
    test_seq();
    test_defer();
    test_partial_mask();
    test_sanitize();
    test_mask_zero();
    test_back_to_back();
    test_reset_mid_gap();
    test_random_traffic();
    test_drop_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcu_cmd_scheduler.md
Name: mcu_cmd_scheduler

Overview:
- Owns the 8 MCU-to-rocstar downlink nibbles (A1..A4, B1..B4) inside mcu_logic.
- Shares each downlink between per-link coincidence results from the coincidence logic and bus-initiated broadcast commands: SYNC, SAVE, RUN and STOP. These are decoded on the rocstar side as sync_clk, save_clk and runmode.
- Sequences the SYNC-gap-SAVE clock-alignment procedure, so every masked board zeroes and latches its clkcnt on the same clk edge.

Parameters:
- BASE_ADDR, 16'h0040: bus address of register 0; registers occupy BASE_ADDR+0..+3.
- MAX_DEFER, 8: cycles a pending command may wait for idle lanes before it preempts coincidence traffic.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- baddr  in  16  bus address
- bwrdata  in  16  bus write data
- bwr  in  1  bus write qualifier
- bstrobe  in  1  one-cycle bus access strobe
- brddata  out  16  read data; 0 when baddr is outside BASE_ADDR..+3 (mcu_logic ORs the sources)
- coinc_valid  in  8  per-link coincidence result present this cycle; bit0=A1 .. bit7=B4
- coinc_code  in  32  per-link 4-bit code, nibble i for link i; legal values 4'h1..4'h7
- link_out  out  32  registered downlink nibbles, nibble i drives link i
- busy  out  1  a command or sequence is in progress

Behaviour:
- Nibble encodings live in the package: IDLE=4'h0, SYNC=4'hA, SAVE=4'hB, RUN=4'hC, STOP=4'hD.
- Registers:
  - +0 CTRL, write-only. A write with bwr&bstrobe starts an operation: bits[2:0] 1=SYNC, 2=SAVE, 3=RUN, 4=STOP, 5=SEQ (SYNC, then gap, then SAVE). Other values are ignored.
  - +1 MASK[7:0]; reset value 8'hFF.
  - +2 GAP[15:0]; reset value 16'd100; GAP=0 is treated as 1.
  - +3 STATUS, read-only: {drop_cnt[7:0], 3'b0, state[2:0], seq_done, busy}.
  - brddata is combinational from baddr.
- CTRL writes while busy=1 are ignored. The register writes are still accepted.
- Reset clears to 0: link_out, busy, state, drop_cnt, seq_done. MASK and GAP return to their reset values.
- FSM states: IDLE, ARM, GAP, ARM2.
  - IDLE + valid CTRL write in cycle T: latch the command, go to ARM at T+1, busy=1 from T+1.
  - ARM, issue condition: no masked lane has coinc_valid, or the defer counter has reached MAX_DEFER.
  - ARM, issue action: on the next edge, every masked lane gets the command nibble for exactly 1 cycle, all on the same edge.
  - ARM, after issue: non-SEQ commands go to IDLE with busy=0 one cycle after the command nibble; SEQ goes to GAP.
  - Best case: command nibble on link_out at cycle T+2.
  - Preempting issue: masked lanes with coinc_valid lose their code. drop_cnt += number of such lanes, saturating at 255.
  - GAP: count GAP cycles, then go to ARM2. The SAVE nibble appears exactly GAP+1 cycles after the SYNC nibble when lanes are idle.
  - ARM2: same issue rules as ARM with the SAVE nibble. On issue go to IDLE and set seq_done=1.
  - seq_done clears on the next CTRL write.
- Unmasked lanes and non-command cycles: link_out[i] = coinc_valid[i] ? coinc_code[i] : IDLE, registered, 1-cycle latency.
  - coinc_code values 0 or >7 are forced to IDLE, so commands cannot be spoofed.
- Defer counter: reset on entry to ARM/ARM2; increments each cycle the issue condition is false.
- A command is always broadcast atomically on all masked lanes. No partial issue.
- MASK=0 in ARM: the command issues immediately with no lane effect; the FSM still progresses.
- rst asserted mid-sequence: returns to IDLE next edge; any in-flight nibble is replaced by IDLE.

Decomposition:
- Package mcu_cmd_pkg: nibble constants, CTRL opcodes, state enum, register offsets.
- One sub-module, mcu_lane_mux: per-lane registered select between coincidence code, command nibble and IDLE, with code sanitising. Instantiated 8x.

Test Plan:
- Reset, then read +1, +2, +3 -> 16'h00FF, 16'd100, 16'h0000; link_out == 0.
- MASK=8'hFF, idle lanes, write CTRL=3 at cycle T -> all nibbles 4'hC at T+2 only; busy=0 at T+3.
- GAP=5, write CTRL=5 -> all lanes 4'hA at T+2 and 4'hB at T+8; STATUS bit1=1 afterwards.
- coinc_valid=8'h01 held continuously with code 4'h3, MASK=8'h01, CTRL=1 -> SYNC delayed to T+2+MAX_DEFER; drop_cnt=1.
- MASK=8'h0F, coinc_valid=8'h80 code 4'h5, CTRL=2 -> nibbles 0-3 = 4'hB at T+2; nibble 7 = 4'h5 in that same cycle.
- coinc_code 4'hA on lane 2 -> link_out lane 2 = 4'h0; rst asserted during GAP -> no SAVE nibble is ever emitted.
